// File: rtl/multicycle_decoder.sv
// multicycle_decoder: Moore main FSM + ALU decoder driving the multicycle ARM datapath controls (raw FlagW/PCS/RegW/MemW/NextPC).
// Latency: outputs are combinational from the current state (plus Funct/Rd); DP=4, LDR=5, STR=4, B=3, undefined=3 cycles.
// Backpressure: none by default; with MULTICYCLE_MEM_WAIT_EN, MemReady=0 holds FETCH, MEMREAD and MEMWRITE.
module multicycle_decoder #(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic               MemReady,
`endif
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUControl,
    output logic [1:0]         FlagW,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic               IllegalInstr,
    output logic [STATE_W-1:0] State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t     state, state_nxt;
    logic       mem_ready;
    logic       irwrite_raw, nextpc_raw, regw_raw, memw_raw, illegal_raw;
    logic       branch, alu_op;
    logic [3:0] cmd;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    assign cmd = Funct[4:1];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = UNKNOWN;
                endcase
            end
            MEMADR:   state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_nxt = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    always_comb begin
        irwrite_raw = 1'b0;
        nextpc_raw  = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        regw_raw    = 1'b0;
        memw_raw    = 1'b0;
        illegal_raw = 1'b0;
        branch      = 1'b0;
        alu_op      = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                irwrite_raw = mem_ready;
                nextpc_raw  = mem_ready;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw_raw  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                memw_raw = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            // CMP only sets flags; it never writes back
            ALUWB:    regw_raw = (cmd != 4'b1010);
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            UNKNOWN:  illegal_raw = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        if (alu_op) begin
            case (cmd)
                4'b0100: begin ALUControl = 2'b00; FlagW = {Funct[0], Funct[0]}; end
                4'b0010: begin ALUControl = 2'b01; FlagW = {Funct[0], Funct[0]}; end
                4'b0000: begin ALUControl = 2'b10; FlagW = {Funct[0], 1'b0};     end
                4'b1100: begin ALUControl = 2'b11; FlagW = {Funct[0], 1'b0};     end
                4'b1010: begin ALUControl = 2'b01; FlagW = 2'b11;                end
                default: begin ALUControl = 2'b00; FlagW = 2'b00;                end
            endcase
        end
    end

    // Write-enables are squashed while reset is held so nothing commits mid-reset
    assign IRWrite      = irwrite_raw & Reset;
    assign NextPC       = nextpc_raw & Reset;
    assign RegW         = regw_raw & Reset;
    assign MemW         = memw_raw & Reset;
    assign IllegalInstr = illegal_raw & Reset;
    assign PCS          = (((Rd == 4'hF) & regw_raw) | branch) & Reset;
    assign State        = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_decoder.sv
// Self-checking bench for multicycle_decoder: directed vector table, reset/wait corner cases, and random instructions vs. a model.
module tb_multicycle_decoder;
    logic       CLK;
    logic       Reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic       MemReady;
`endif
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW, IllegalInstr;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic [3:0] State;

    multicycle_decoder #(.STATE_W(4)) dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Rd(Rd),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .MemReady(MemReady),
`endif
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .IllegalInstr(IllegalInstr), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic       irw, npc, adr, sa;
        logic [1:0] sb, rs, ac, fw;
        logic       pcs, rw, mw, ill;
    } rec_t;

    typedef struct packed {
        logic [1:0]      op;
        logic [5:0]      funct;
        logic [3:0]      rd;
        logic [2:0]      len;
        logic [0:5][3:0] st;
        logic [0:5]      regw, memw, pcs, ill;
        logic [1:0]      alu, fw;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    rec_t act;
    rec_t exp_q[$];
    vec_t vecs[12];

    always_comb act = {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                       ALUControl, FlagW, PCS, RegW, MemW, IllegalInstr};

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic chk_rec(input string name, input rec_t want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %05h expected %05h (state %0d vs %0d)", name, act, want, act.st, want.st);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: mnemonic-level ALU behaviour -> {ALUControl, FlagW}
    function automatic logic [3:0] alu_ref(input logic [3:0] cmd, input logic s);
        case (cmd)
            4'b0100: return {2'b00, s, s};   // ADD
            4'b0010: return {2'b01, s, s};   // SUB
            4'b0000: return {2'b10, s, 1'b0}; // AND
            4'b1100: return {2'b11, s, 1'b0}; // ORR
            4'b1010: return 4'b0111;          // CMP
            default: return 4'b0000;
        endcase
    endfunction

    function automatic rec_t blank(input logic [3:0] st);
        rec_t e = '0;
        e.st = st;
        return e;
    endfunction

    // Reference: expand one instruction into its per-cycle control records
    function automatic void model_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
        rec_t e;
        e = blank(4'd0); e.irw = 1; e.npc = 1; e.sa = 1; e.sb = 2'b10; e.rs = 2'b10; exp_q.push_back(e);
        e = blank(4'd1); e.sa = 1; e.sb = 2'b10; e.rs = 2'b10; exp_q.push_back(e);
        case (op)
            2'b00: begin
                e = blank(f[5] ? 4'd7 : 4'd6);
                e.sb = f[5] ? 2'b01 : 2'b00;
                {e.ac, e.fw} = alu_ref(f[4:1], f[0]);
                exp_q.push_back(e);
                e = blank(4'd8); e.rw = (f[4:1] != 4'b1010); e.pcs = e.rw && (rd == 4'hF);
                exp_q.push_back(e);
            end
            2'b01: begin
                e = blank(4'd2); e.sb = 2'b01; exp_q.push_back(e);
                if (f[0]) begin
                    e = blank(4'd3); e.adr = 1; exp_q.push_back(e);
                    e = blank(4'd4); e.rs = 2'b01; e.rw = 1; e.pcs = (rd == 4'hF); exp_q.push_back(e);
                end else begin
                    e = blank(4'd5); e.adr = 1; e.mw = 1; exp_q.push_back(e);
                end
            end
            2'b10: begin
                e = blank(4'd9); e.sb = 2'b01; e.rs = 2'b10; e.pcs = 1; exp_q.push_back(e);
            end
            default: begin
                e = blank(4'd10); e.ill = 1; exp_q.push_back(e);
            end
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t rst_rec;
        // op, funct, rd, len, states, regw, memw, pcs, ill, alu@c2, flagw@c2
        vecs[0]  = '{2'b00, 6'b001001, 4'd3,  3'd5, {4'd0,4'd1,4'd6,4'd8,4'd0,4'd0}, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 2'b00, 2'b11}; // ADDS
        vecs[1]  = '{2'b01, 6'b011001, 4'd2,  3'd6, {4'd0,4'd1,4'd2,4'd3,4'd4,4'd0}, 6'b000010, 6'b000000, 6'b000000, 6'b000000, 2'b00, 2'b00}; // LDR
        vecs[2]  = '{2'b01, 6'b011000, 4'd2,  3'd5, {4'd0,4'd1,4'd2,4'd5,4'd0,4'd0}, 6'b000000, 6'b000100, 6'b000000, 6'b000000, 2'b00, 2'b00}; // STR
        vecs[3]  = '{2'b00, 6'b110101, 4'd0,  3'd5, {4'd0,4'd1,4'd7,4'd8,4'd0,4'd0}, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 2'b01, 2'b11}; // CMP imm
        vecs[4]  = '{2'b10, 6'b000000, 4'd0,  3'd4, {4'd0,4'd1,4'd9,4'd0,4'd0,4'd0}, 6'b000000, 6'b000000, 6'b001000, 6'b000000, 2'b00, 2'b00}; // B
        vecs[5]  = '{2'b11, 6'b000000, 4'd0,  3'd4, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0},6'b000000, 6'b000000, 6'b000000, 6'b001000, 2'b00, 2'b00}; // undefined
        vecs[6]  = '{2'b00, 6'b000100, 4'd15, 3'd5, {4'd0,4'd1,4'd6,4'd8,4'd0,4'd0}, 6'b000100, 6'b000000, 6'b000100, 6'b000000, 2'b01, 2'b00}; // SUB to PC
        vecs[7]  = '{2'b01, 6'b011001, 4'd15, 3'd6, {4'd0,4'd1,4'd2,4'd3,4'd4,4'd0}, 6'b000010, 6'b000000, 6'b000010, 6'b000000, 2'b00, 2'b00}; // LDR to PC
        vecs[8]  = '{2'b00, 6'b100001, 4'd1,  3'd5, {4'd0,4'd1,4'd7,4'd8,4'd0,4'd0}, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 2'b10, 2'b10}; // ANDS imm
        vecs[9]  = '{2'b00, 6'b011001, 4'd4,  3'd5, {4'd0,4'd1,4'd6,4'd8,4'd0,4'd0}, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 2'b11, 2'b10}; // ORRS
        vecs[10] = '{2'b00, 6'b000011, 4'd5,  3'd5, {4'd0,4'd1,4'd6,4'd8,4'd0,4'd0}, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 2'b00, 2'b00}; // other cmd
        vecs[11] = '{2'b00, 6'b101000, 4'd6,  3'd5, {4'd0,4'd1,4'd7,4'd8,4'd0,4'd0}, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 2'b00, 2'b00}; // ADD imm, S=0

        Reset = 1'b0; Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
`ifdef MULTICYCLE_MEM_WAIT_EN
        MemReady = 1'b1;
`endif
        rst_rec = blank(4'd0); rst_rec.sa = 1; rst_rec.sb = 2'b10; rst_rec.rs = 2'b10;
        step(); chk_rec("reset_c1", rst_rec);
        step(); chk_rec("reset_c2", rst_rec);
        Reset = 1'b1; #1;
        chk("post_reset_irwrite", 8'(IRWrite), 8'd1);
        chk("post_reset_nextpc", 8'(NextPC), 8'd1);
        chk("post_reset_state", 8'(State), 8'd0);

        for (int v = 0; v < 12; v++) begin
            Op = vecs[v].op; Funct = vecs[v].funct; Rd = vecs[v].rd; #1;
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                chk($sformatf("vec%0d_c%0d_state", v, i), 8'(State), 8'(vecs[v].st[i]));
                chk($sformatf("vec%0d_c%0d_regw", v, i), 8'(RegW), 8'(vecs[v].regw[i]));
                chk($sformatf("vec%0d_c%0d_memw", v, i), 8'(MemW), 8'(vecs[v].memw[i]));
                chk($sformatf("vec%0d_c%0d_pcs", v, i), 8'(PCS), 8'(vecs[v].pcs[i]));
                chk($sformatf("vec%0d_c%0d_ill", v, i), 8'(IllegalInstr), 8'(vecs[v].ill[i]));
                if (i == 2) begin
                    chk($sformatf("vec%0d_aluctl", v), 8'(ALUControl), 8'(vecs[v].alu));
                    chk($sformatf("vec%0d_flagw", v), 8'(FlagW), 8'(vecs[v].fw));
                end
                if (i < int'(vecs[v].len) - 1) step();
            end
        end

        // Reset asserted mid-LDR (in MEMREAD) abandons the load
        Op = 2'b01; Funct = 6'b011001; Rd = 4'hF; #1;
        step(); step(); step();
        chk("midrst_pre_state", 8'(State), 8'd3);
        Reset = 1'b0; #1;
        chk("midrst_async_state", 8'(State), 8'd0);
        chk("midrst_async_regw", 8'(RegW), 8'd0);
        chk("midrst_async_pcs", 8'(PCS), 8'd0);
        step();
        chk("midrst_hold_state", 8'(State), 8'd0);
        chk("midrst_hold_regw", 8'(RegW), 8'd0);
        chk("midrst_hold_irwrite", 8'(IRWrite), 8'd0);
        Reset = 1'b1; #1;
        chk("midrst_fetch_irwrite", 8'(IRWrite), 8'd1);
        step(); chk("midrst_decode", 8'(State), 8'd1);
        step(); step(); step(); step();
        chk("midrst_back_to_fetch", 8'(State), 8'd0);

`ifdef MULTICYCLE_MEM_WAIT_EN
        // FETCH stall, then STR with three wait cycles in MEMWRITE
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd0; MemReady = 1'b0; #1;
        chk("wait_fetch_irwrite", 8'(IRWrite), 8'd0);
        chk("wait_fetch_nextpc", 8'(NextPC), 8'd0);
        step(); chk("wait_fetch_hold", 8'(State), 8'd0);
        MemReady = 1'b1; #1;
        chk("wait_fetch_go_irwrite", 8'(IRWrite), 8'd1);
        step(); chk("wait_decode", 8'(State), 8'd1);
        step(); chk("wait_memadr", 8'(State), 8'd2);
        step(); MemReady = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wait_memwrite_state_%0d", k), 8'(State), 8'd5);
            chk($sformatf("wait_memwrite_memw_%0d", k), 8'(MemW), 8'd1);
            step();
        end
        MemReady = 1'b1; #1;
        chk("wait_memwrite_state_3", 8'(State), 8'd5);
        chk("wait_memwrite_memw_3", 8'(MemW), 8'd1);
        step(); chk("wait_done_fetch", 8'(State), 8'd0);
`endif

        for (int n = 0; n < 150; n++) begin
            Op = 2'($urandom_range(0, 3)); Funct = 6'($urandom); Rd = 4'($urandom);
            exp_q.delete();
            model_instr(Op, Funct, Rd);
            #1;
            for (int i = 0; i < exp_q.size(); i++) begin
                chk_rec($sformatf("rand%0d_c%0d", n, i), exp_q[i]);
                step();
            end
        end
        #1;
        chk("final_fetch", 8'(State), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_decoder.md
Name: multicycle_decoder

Overview:
- Control-signal producer for the multicycle ARM datapath; it is the upstream end of condlogic.
- Decodes Op/Funct/Rd with a Moore main FSM plus an ALU decoder.
- Emits the raw, unconditioned FlagW, PCS, RegW, MemW and NextPC that condlogic gates with Cond/ALUFlags.
- Also drives datapath mux selects and IRWrite for the current instruction phase.

Parameters:
- STATE_W, 4, width of the exported state encoding; must be ≥4.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L.
- Rd  in  4  Instr[15:12].
- IRWrite  out  1  instruction register load.
- NextPC  out  1  PC update request (unconditional part).
- AdrSrc  out  1  memory address select (0=PC, 1=ALUOut).
- ALUSrcA  out  1  ALU A select.
- ALUSrcB  out  2  ALU B select.
- ResultSrc  out  2  result mux select.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- FlagW  out  2  [1]=NZ write, [0]=CV write.
- PCS  out  1  PC-write-by-instruction.
- RegW  out  1  register write request.
- MemW  out  1  memory write request.
- IllegalInstr  out  1  asserted in state UNKNOWN.
- State  out  STATE_W  current state code, debug.

Behaviour:
- State register updates on CLK rising edge. All outputs are combinational from State, plus Funct and Rd where noted.
- Reset low: State=FETCH immediately (async). While Reset is low, IRWrite, NextPC, RegW, MemW, PCS and IllegalInstr are forced to 0; other outputs show FETCH values.
- Reset mid-instruction abandons the instruction. The first cycle after Reset deassertion is a full FETCH.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10
  - Codes 11-15 go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE:
    - Op=00, Funct[5]=0 → EXECUTER
    - Op=00, Funct[5]=1 → EXECUTEI
    - Op=01 → MEMADR
    - Op=10 → BRANCH
    - Op=11 → UNKNOWN
  - MEMADR: Funct[0]=1 → MEMREAD, else → MEMWRITE.
  - MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH. BRANCH→FETCH. UNKNOWN→FETCH.
- Output table (unlisted outputs are 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcA=0, ALUSrcB=01
  - MEMREAD: ResultSrc=00, AdrSrc=1
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemW=1
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1 unless cmd=1010 (CMP)
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1
  - UNKNOWN: IllegalInstr=1
- ALU decoder, ALUOp=1 (cmd=Funct[4:1]):
  - 0100 ADD→00; 0010 SUB→01; 0000 AND→10; 1100 ORR→11
  - 1010 CMP→01 with FlagW=11
  - Any other cmd→00, FlagW=00
  - Otherwise FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is ADD or SUB)
- ALU decoder, ALUOp=0: ALUControl=00, FlagW=00.
- FlagW is nonzero only in EXECUTER/EXECUTEI. condlogic latches flags on that cycle.
- PCS=(Rd==4'hF & RegW) | Branch.
- Instruction latency: DP=4 cycles, LDR=5, STR=4, B=3, undefined=3.

Optional Feature:
- Macro MULTICYCLE_MEM_WAIT_EN.
- When defined, adds input port MemReady (1 bit, after Rd).
- FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
- In FETCH, IRWrite and NextPC are asserted only in the cycle MemReady=1.
- MemW stays high throughout MEMWRITE while waiting.
- When undefined, no MemReady port; every state lasts exactly one cycle.

Test Plan:
- Reset=0 for 2 cycles, then 1 → State=0 during reset with IRWrite=0. First post-reset cycle has IRWrite=1, NextPC=1.
- ADD register, S=1 (Op=00, Funct=001001, Rd=3) → States 0,1,6,8,0.
  - Cycle 3: ALUControl=00, FlagW=11.
  - Cycle 4: RegW=1, PCS=0.
- LDR (Op=01, Funct=011001) → States 0,1,2,3,4,0. RegW only in MEMWB. STR (Funct=011000) → 0,1,2,5,0 with MemW=1 in cycle 4 only.
- CMP (Op=00, Funct=110101) → EXECUTEI: ALUControl=01, FlagW=11. ALUWB: RegW=0. B (Op=10) → 0,1,9,0 with PCS=1 in BRANCH.
- Op=11 → UNKNOWN with IllegalInstr=1 for one cycle, then FETCH. Reset pulled low in MEMREAD → State=0 asynchronously and RegW never asserts.
- With MULTICYCLE_MEM_WAIT_EN: MemReady low 3 cycles in MEMWRITE → State held at 5 for 4 cycles with MemW=1, then FETCH.
